// File: rtl/updown_counter_param.sv
// updown_counter_param: loadable up/down counter with modulus, wrap/saturate, sticky flags
// clk, reset (async, active-high), en, load, ud (1=up), data_in, clr_flags
//   -> data_out, tc (combinational), wrap_pulse, ovf_flag, unf_flag
module updown_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             ud,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_flag,
    output logic             unf_flag
);
    localparam logic [WIDTH-1:0] MAX = MAX_COUNT[WIDTH-1:0];
    logic             at_max, at_min, up_evt, dn_evt;
    logic [WIDTH-1:0] cnt_nxt;
    always_comb begin
        at_max  = data_out == MAX;
        at_min  = data_out == '0;
        up_evt  = !load && en && ud && at_max;
        dn_evt  = !load && en && !ud && at_min;
        cnt_nxt = load    ? ((data_in > MAX) ? MAX : data_in) :
                  !en     ? data_out :
                  up_evt  ? (SATURATE ? MAX : '0) :
                  dn_evt  ? (SATURATE ? '0 : MAX) :
                  ud      ? data_out + 1'b1 : data_out - 1'b1;
        tc      = ud ? at_max : at_min;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            wrap_pulse <= 1'b0;
            ovf_flag   <= 1'b0;
            unf_flag   <= 1'b0;
        end else begin
            data_out   <= cnt_nxt;
            wrap_pulse <= up_evt || dn_evt;
            // a boundary event in the clearing cycle keeps the flag set
            ovf_flag   <= up_evt || (ovf_flag && !clr_flags);
            unf_flag   <= dn_evt || (unf_flag && !clr_flags);
        end
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: checks wrap and saturate instances against an arithmetic model
module tb_updown_counter_param;
    localparam int MAXC = 9;
    logic       clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0, ud = 1'b0, clr_flags = 1'b0;
    logic [3:0] data_in = '0;
    logic [3:0] dout_w, dout_s;
    logic       tc_w, tc_s, wp_w, wp_s, ovf_w, ovf_s, unf_w, unf_s;
    int         tests = 0, fails = 0;
    int         cnt [2];
    bit         pulse [2], ovf [2], unf [2];

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(MAXC), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .load(load), .ud(ud), .data_in(data_in),
        .clr_flags(clr_flags), .data_out(dout_w), .tc(tc_w), .wrap_pulse(wp_w),
        .ovf_flag(ovf_w), .unf_flag(unf_w));
    updown_counter_param #(.WIDTH(4), .MAX_COUNT(MAXC), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .load(load), .ud(ud), .data_in(data_in),
        .clr_flags(clr_flags), .data_out(dout_s), .tc(tc_s), .wrap_pulse(wp_s),
        .ovf_flag(ovf_s), .unf_flag(unf_s));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0; pulse[m] = 0; ovf[m] = 0; unf[m] = 0;
        end
    endtask

    // m=0 wraps at the range ends, m=1 saturates
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            bit up_e, dn_e;
            up_e = 0; dn_e = 0;
            if (load) cnt[m] = (int'(data_in) > MAXC) ? MAXC : int'(data_in);
            else if (en && ud) begin
                if (cnt[m] == MAXC) begin up_e = 1; cnt[m] = (m == 1) ? MAXC : 0; end
                else cnt[m] = cnt[m] + 1;
            end else if (en) begin
                if (cnt[m] == 0) begin dn_e = 1; cnt[m] = (m == 1) ? 0 : MAXC; end
                else cnt[m] = cnt[m] - 1;
            end
            pulse[m] = up_e || dn_e;
            ovf[m] = up_e || (ovf[m] && !clr_flags);
            unf[m] = dn_e || (unf[m] && !clr_flags);
        end
    endtask

    task automatic check_all(input string tag);
        bit tw, ts;
        tw = ud ? (cnt[0] == MAXC) : (cnt[0] == 0);
        ts = ud ? (cnt[1] == MAXC) : (cnt[1] == 0);
        chk({tag, ".w.data_out"}, 8'(dout_w), 8'(cnt[0]));
        chk({tag, ".w.tc"}, 8'(tc_w), 8'(tw));
        chk({tag, ".w.wrap_pulse"}, 8'(wp_w), 8'(pulse[0]));
        chk({tag, ".w.ovf"}, 8'(ovf_w), 8'(ovf[0]));
        chk({tag, ".w.unf"}, 8'(unf_w), 8'(unf[0]));
        chk({tag, ".s.data_out"}, 8'(dout_s), 8'(cnt[1]));
        chk({tag, ".s.tc"}, 8'(tc_s), 8'(ts));
        chk({tag, ".s.wrap_pulse"}, 8'(wp_s), 8'(pulse[1]));
        chk({tag, ".s.ovf"}, 8'(ovf_s), 8'(ovf[1]));
        chk({tag, ".s.unf"}, 8'(unf_s), 8'(unf[1]));
    endtask

    task automatic step(input string tag, input bit l, input bit e, input bit u,
                        input logic [3:0] d, input bit c);
        load = l; en = e; ud = u; data_in = d; clr_flags = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step("t1_up", 0, 1, 1, 0, 0);
        step("t2_load5", 1, 0, 0, 4'd5, 0);
        for (int i = 0; i < 7; i++) step("t2_down", 0, 1, 0, 0, 0);
        step("t5_clr_idle", 0, 0, 0, 0, 1);
        chk("t5_flags_clear", 8'({ovf_w, unf_w, ovf_s, unf_s}), 8'd0);
        step("t3_load8", 1, 0, 1, 4'd8, 0);
        for (int i = 0; i < 3; i++) step("t3_up_sat", 0, 1, 1, 0, 0);
        chk("t3_sat_hold", 8'(dout_s), 8'd9);
        step("t4_load14_en", 1, 1, 0, 4'd14, 0);
        chk("t4_clamp", 8'(dout_w), 8'd9);
        step("t5_clr_on_evt", 0, 1, 1, 0, 1);
        chk("t5_set_wins", 8'({ovf_w, ovf_s}), 8'd3);
        step("t6_load6", 1, 0, 1, 4'd6, 0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("t6_async_reset");
        chk("t6_all_zero", 8'({dout_w, tc_w, wp_w, ovf_w, unf_w}), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
